// File: rtl/ingress_flit_assembler.sv
// Receive-side flit reassembler: arbitrates four input links round-robin and
// rebuilds 3-header + 1-payload flit packets into a 96-bit header and 32-bit payload.
module ingress_flit_assembler #(
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [159:0]             in_flit,
  input  logic [3:0]               in_valid,
  output logic [3:0]               in_ready,
  output logic [95:0]              header_out,
  output logic [31:0]              payload_out,
  output logic [1:0]               in_port,
  output logic [1:0]               src_link,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     err_pulse,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  typedef enum logic [2:0] {ARB, HDR1, HDR2, PAY, OUT} state_t;

  state_t                   r_state;
  logic [1:0]               r_rr_ptr;
  logic [95:0]              r_hdr;
  logic [31:0]              r_pay;
  logic [1:0]               r_in_port;
  logic [1:0]               r_src_link;
  logic                     r_out_valid;
  logic                     r_err_pulse;
  logic [ERR_CNT_WIDTH-1:0] r_err_cnt;

  logic       w_any;
  logic [1:0] w_grant;
  logic [1:0] w_sel;
  logic [3:0] w_in_ready;
  logic       w_acc;
  logic       w_marker;
  logic [1:0] w_snd;
  logic [31:0] w_data;
  logic       w_err;
  logic       w_unused_rsvd;

  function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Iterating downward leaves the nearest valid link at or after rr_ptr as the winner.
  always_comb begin
    logic [1:0] idx;
    w_any   = 1'b0;
    w_grant = r_rr_ptr;
    idx     = r_rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = r_rr_ptr + 2'(k);
      if (in_valid[idx]) begin
        w_any   = 1'b1;
        w_grant = idx;
      end
    end
  end

  assign w_sel = (r_state == ARB) ? w_grant : r_in_port;

  always_comb begin
    w_in_ready = '0;
    if (rst_n) begin
      case (r_state)
        ARB:             if (w_any) w_in_ready[w_grant] = 1'b1;
        HDR1, HDR2, PAY: if (in_valid[r_in_port]) w_in_ready[r_in_port] = 1'b1;
        default:         w_in_ready = '0;
      endcase
    end
  end

  assign w_acc = |w_in_ready;

  always_comb begin
    w_marker = 1'b0;
    w_snd    = '0;
    w_data   = '0;
    case (w_sel)
      2'd0: begin w_marker = in_flit[39];  w_snd = in_flit[33:32];   w_data = in_flit[31:0];    end
      2'd1: begin w_marker = in_flit[79];  w_snd = in_flit[73:72];   w_data = in_flit[71:40];   end
      2'd2: begin w_marker = in_flit[119]; w_snd = in_flit[113:112]; w_data = in_flit[111:80];  end
      default: begin w_marker = in_flit[159]; w_snd = in_flit[153:152]; w_data = in_flit[151:120]; end
    endcase
  end

  assign w_unused_rsvd = ^{in_flit[38:34], in_flit[78:74], in_flit[118:114], in_flit[158:154]};

  // A stray continuation in ARB or a fresh first flit mid-packet is a protocol error.
  assign w_err = w_acc && ((r_state == ARB) ? !w_marker : w_marker);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ARB;
      r_rr_ptr    <= '0;
      r_hdr       <= '0;
      r_pay       <= '0;
      r_in_port   <= '0;
      r_src_link  <= '0;
      r_out_valid <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_err_pulse <= w_err;
      if (w_err) r_err_cnt <= sat_inc(r_err_cnt);

      case (r_state)
        ARB: begin
          if (w_acc) begin
            if (w_marker) begin
              r_hdr[31:0] <= w_data;
              r_src_link  <= w_snd;
              r_in_port   <= w_grant;
              r_state     <= HDR1;
            end else begin
              r_rr_ptr <= w_grant + 2'd1;
            end
          end
        end
        HDR1, HDR2, PAY: begin
          if (w_acc) begin
            if (w_marker) begin
              r_hdr[31:0] <= w_data;
              r_src_link  <= w_snd;
              r_state     <= HDR1;
            end else begin
              case (r_state)
                HDR1: begin r_hdr[63:32] <= w_data; r_state <= HDR2; end
                HDR2: begin r_hdr[95:64] <= w_data; r_state <= PAY;  end
                default: begin
                  r_pay       <= w_data;
                  r_out_valid <= 1'b1;
                  r_state     <= OUT;
                end
              endcase
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_rr_ptr    <= r_in_port + 2'd1;
            r_state     <= ARB;
          end
        end
        default: r_state <= ARB;
      endcase
    end
  end

  assign in_ready    = w_in_ready;
  assign header_out  = r_hdr;
  assign payload_out = r_pay;
  assign in_port     = r_in_port;
  assign src_link    = r_src_link;
  assign out_valid   = r_out_valid;
  assign err_pulse   = r_err_pulse;
  assign err_count   = r_err_cnt;

endmodule

// File: tb/tb_ingress_flit_assembler.sv
// Bench for ingress_flit_assembler: per-link flit queues drive the links and a
// transaction-level model predicts grants, delivered packets and error counts.
module tb_ingress_flit_assembler;
  localparam int EW = 8;
  localparam int EMAX = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [159:0]  in_flit;
  logic [3:0]    in_valid;
  logic [3:0]    in_ready;
  logic [95:0]   header_out;
  logic [31:0]   payload_out;
  logic [1:0]    in_port;
  logic [1:0]    src_link;
  logic          out_valid;
  logic          out_ready;
  logic          err_pulse;
  logic [EW-1:0] err_count;

  always #5 clk = ~clk;

  ingress_flit_assembler #(.ERR_CNT_WIDTH(EW)) dut (
    .clk(clk), .rst_n(rst_n), .in_flit(in_flit), .in_valid(in_valid),
    .in_ready(in_ready), .header_out(header_out), .payload_out(payload_out),
    .in_port(in_port), .src_link(src_link), .out_valid(out_valid),
    .out_ready(out_ready), .err_pulse(err_pulse), .err_count(err_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [39:0] lq [4][$];

  bit          m_busy, m_out, m_pulse;
  int          m_port, m_rr, m_cnt, m_errs;
  logic [95:0] m_hdr;
  logic [31:0] m_pay;
  logic [1:0]  m_src;

  int          d_port[$];
  int          d_cyc[$];
  logic [95:0] d_hdr[$];
  logic [31:0] d_pay[$];
  logic [1:0]  d_src[$];
  int          cyc = 0;

  function automatic logic [39:0] mk_flit(input bit mk, input logic [1:0] snd, input logic [31:0] d);
    logic [4:0] rsv;
    rsv = 5'($urandom);
    return {mk, rsv, snd, d};
  endfunction

  task automatic push_pkt(input int l, input logic [1:0] snd, input logic [95:0] h, input logic [31:0] p);
    lq[l].push_back(mk_flit(1'b1, snd, h[31:0]));
    lq[l].push_back(mk_flit(1'b0, snd, h[63:32]));
    lq[l].push_back(mk_flit(1'b0, snd, h[95:64]));
    lq[l].push_back(mk_flit(1'b0, snd, p));
  endtask

  task automatic clr_d();
    d_port.delete(); d_cyc.delete(); d_hdr.delete(); d_pay.delete(); d_src.delete();
  endtask

  task automatic model_reset();
    m_busy = 0; m_out = 0; m_pulse = 0;
    m_port = 0; m_rr = 0; m_cnt = 0; m_errs = 0;
    m_hdr = '0; m_pay = '0; m_src = '0;
    for (int l = 0; l < 4; l++) lq[l].delete();
    clr_d();
  endtask

  task automatic model_error();
    m_pulse = 1;
    if (m_errs < EMAX) m_errs++;
  endtask

  // Each iteration: drive at negedge, compare against the model, then let the posedge commit.
  task automatic run(input int n, input int gap_pct, input int hold_pct);
    logic [3:0]  v, exp_rdy;
    logic [39:0] f;
    int          g;
    repeat (n) begin
      @(negedge clk);
      for (int l = 0; l < 4; l++) begin
        v[l] = (lq[l].size() > 0) && ($urandom_range(0, 99) >= gap_pct);
        if (v[l]) in_flit[l*40 +: 40] = lq[l][0];
        else      in_flit[l*40 +: 40] = 40'h0;
      end
      in_valid  = v;
      out_ready = ($urandom_range(0, 99) >= hold_pct);
      #1;
      g = -1;
      if (!m_out) begin
        if (m_busy) begin
          if (v[m_port]) g = m_port;
        end else begin
          for (int k = 0; k < 4; k++)
            if (g < 0 && v[(m_rr + k) % 4]) g = (m_rr + k) % 4;
        end
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check_eq("in_ready", in_ready, exp_rdy);
      check_eq("out_valid", out_valid, m_out);
      check_eq("err_pulse", err_pulse, m_pulse);
      check_eq("err_count", err_count, m_errs);
      if (m_out) begin
        check_eq("header_out", header_out, m_hdr);
        check_eq("payload_out", payload_out, m_pay);
        check_eq("in_port", in_port, m_port);
        check_eq("src_link", src_link, m_src);
      end
      m_pulse = 0;
      if (m_out && out_ready) begin
        d_port.push_back(m_port); d_cyc.push_back(cyc);
        d_hdr.push_back(m_hdr); d_pay.push_back(m_pay); d_src.push_back(m_src);
        m_out = 0;
        m_rr  = (m_port + 1) % 4;
      end
      if (g >= 0) begin
        f = lq[g].pop_front();
        if (f[39]) begin
          if (m_busy) model_error();
          m_busy = 1; m_port = g; m_cnt = 1;
          m_hdr[31:0] = f[31:0];
          m_src = f[33:32];
        end else if (!m_busy) begin
          model_error();
          m_rr = (g + 1) % 4;
        end else begin
          if (m_cnt < 3) m_hdr[32*m_cnt +: 32] = f[31:0];
          else begin
            m_pay  = f[31:0];
            m_busy = 0;
            m_out  = 1;
          end
          m_cnt++;
        end
      end
      cyc++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_flit   = {$urandom, $urandom, $urandom, $urandom, $urandom};
    in_valid  = 4'hF;
    out_ready = 1'b1;
    #1;
    check_eq("rst_in_ready", in_ready, 4'h0);
    @(negedge clk);
    check_eq("rst_in_ready2", in_ready, 4'h0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_header", header_out, 0);
    check_eq("rst_payload", payload_out, 0);
    check_eq("rst_in_port", in_port, 0);
    check_eq("rst_src_link", src_link, 0);
    check_eq("rst_err_pulse", err_pulse, 0);
    check_eq("rst_err_count", err_count, 0);
    rst_n    = 1'b1;
    in_valid = 4'h0;
    model_reset();
  endtask

  task automatic check_pkt(input string tag, input int idx, input int port, input logic [1:0] src,
                           input logic [95:0] h, input logic [31:0] p);
    check_eq({tag, "_present"}, d_port.size() > idx, 1);
    if (d_port.size() > idx) begin
      check_eq({tag, "_port"}, d_port[idx], port);
      check_eq({tag, "_src"}, d_src[idx], src);
      check_eq({tag, "_hdr"}, d_hdr[idx], h);
      check_eq({tag, "_pay"}, d_pay[idx], p);
    end
  endtask

  initial begin
    logic [95:0] h;
    logic [31:0] p;
    logic [31:0] bd [4];
    int          total;
    rst_n = 1'b0; in_flit = '0; in_valid = '0; out_ready = 1'b0;
    model_reset();

    // Single packet on link 2
    do_reset();
    push_pkt(2, 2'b01, 96'h0000_0003_0000_0002_0000_0001, 32'hDEADBEEF);
    run(8, 0, 0);
    check_eq("single_count", d_port.size(), 1);
    check_pkt("single", 0, 2, 2'b01, 96'h0000_0003_0000_0002_0000_0001, 32'hDEADBEEF);
    check_eq("single_errs", err_count, 0);

    // Round-robin fairness with all links busy
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int l = 0; l < 4; l++)
        push_pkt(l, 2'(3 - l), {$urandom, $urandom, $urandom}, $urandom);
    run(45, 0, 0);
    check_eq("rr_count", d_port.size(), 8);
    for (int i = 0; i < 8 && i < d_port.size(); i++) begin
      check_eq("rr_order", d_port[i], i % 4);
      if (i > 0) check_eq("rr_period", d_cyc[i] - d_cyc[i-1], 5);
    end

    // Stray continuation flit on link 1
    do_reset();
    lq[1].push_back(mk_flit(1'b0, 2'b10, $urandom));
    run(4, 0, 0);
    check_eq("stray_errs", err_count, 1);
    check_eq("stray_nopkt", d_port.size(), 0);
    check_eq("stray_consumed", lq[1].size(), 0);

    // Premature first flit while waiting for the payload
    do_reset();
    for (int i = 0; i < 4; i++) bd[i] = $urandom;
    lq[0].push_back(mk_flit(1'b1, 2'b00, 32'hAAAA0000));
    lq[0].push_back(mk_flit(1'b0, 2'b00, 32'hAAAA0001));
    lq[0].push_back(mk_flit(1'b0, 2'b00, 32'hAAAA0002));
    lq[0].push_back(mk_flit(1'b1, 2'b10, bd[0]));
    lq[0].push_back(mk_flit(1'b0, 2'b10, bd[1]));
    lq[0].push_back(mk_flit(1'b0, 2'b10, bd[2]));
    lq[0].push_back(mk_flit(1'b0, 2'b10, bd[3]));
    run(12, 0, 0);
    check_eq("prem_errs", err_count, 1);
    check_eq("prem_count", d_port.size(), 1);
    check_pkt("prem", 0, 0, 2'b10, {bd[2], bd[1], bd[0]}, bd[3]);

    // Back-pressure: packet held in OUT while another link waits
    do_reset();
    h = {$urandom, $urandom, $urandom}; p = $urandom;
    push_pkt(1, 2'b11, h, p);
    push_pkt(2, 2'b00, {$urandom, $urandom, $urandom}, $urandom);
    run(14, 0, 100);
    check_eq("bp_held", d_port.size(), 0);
    check_eq("bp_link2_untouched", lq[2].size(), 4);
    run(1, 0, 0);
    check_eq("bp_release", d_port.size(), 1);
    run(6, 0, 100);
    check_eq("bp_single_hs", d_port.size(), 1);
    check_pkt("bp", 0, 1, 2'b11, h, p);

    // Reset in HDR2, then a clean packet
    do_reset();
    push_pkt(3, 2'b01, {$urandom, $urandom, $urandom}, $urandom);
    run(2, 0, 0);
    do_reset();
    h = {$urandom, $urandom, $urandom}; p = $urandom;
    push_pkt(3, 2'b10, h, p);
    run(8, 0, 0);
    check_pkt("after_rst", 0, 3, 2'b10, h, p);
    check_eq("after_rst_errs", err_count, 0);

    // Error counter saturation
    do_reset();
    for (int i = 0; i < 300; i++) lq[i % 4].push_back(mk_flit(1'b0, 2'(i), $urandom));
    run(310, 0, 0);
    check_eq("sat_count", err_count, EMAX);
    check_eq("sat_nopkt", d_port.size(), 0);

    // Randomized traffic with gaps, back-pressure and occasional strays
    do_reset();
    for (int l = 0; l < 4; l++)
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 4) == 0) lq[l].push_back(mk_flit(1'b0, 2'(l), $urandom));
        push_pkt(l, 2'($urandom), {$urandom, $urandom, $urandom}, $urandom);
      end
    run(700, 30, 30);
    run(200, 0, 0);
    total = 0;
    for (int l = 0; l < 4; l++) total += lq[l].size();
    check_eq("rand_drained", total, 0);
    check_eq("rand_pkts", d_port.size(), 32);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
